// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed three-state sequencer sharing one data-RAM port
// between the CPU MEM stage (port C) and the debug/loader port (port D).
module dmem_arbiter #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    output logic              c_err,
    output logic              stall_cpu,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_grant;
    logic                w_grant_nxt;
    logic                w_sel_we;
    logic [31:0]         w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_in_range;
    logic [DATA_W-1:0]   r_c_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_c_err;
    logic                r_d_err;

    // r_grant doubles as last_grant: it only changes on entry to ACC (1 = D).
    assign w_grant_nxt = (c_req && d_req) ? ~r_grant : d_req;

    assign w_sel_we    = r_grant ? d_we    : c_we;
    assign w_sel_addr  = r_grant ? d_addr  : c_addr;
    assign w_sel_wdata = r_grant ? d_wdata : c_wdata;
    assign w_in_range  = (w_sel_addr[31:ADDR_BITS] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (c_req || d_req) w_next = S_ACC;
            S_ACC:   w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        c_ack     = 1'b0;
        d_ack     = 1'b0;
        case (r_state)
            S_ACC: begin
                mem_we    = w_sel_we & w_in_range;
                mem_addr  = {{(32-ADDR_BITS){1'b0}}, w_sel_addr[ADDR_BITS-1:0]};
                mem_wdata = w_sel_wdata;
            end
            S_ACK: begin
                c_ack = ~r_grant;
                d_ack = r_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= 1'b1;
        end else if (r_state == S_IDLE && (c_req || d_req)) begin
            r_grant <= w_grant_nxt;
        end
    end

    // Read data is sampled at the edge closing ACC; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_rdata <= '0;
            r_d_rdata <= '0;
            r_c_err   <= 1'b0;
            r_d_err   <= 1'b0;
        end else if (r_state == S_ACC) begin
            if (r_grant) begin
                r_d_rdata <= w_in_range ? mem_rdata : '0;
                r_d_err   <= ~w_in_range;
            end else begin
                r_c_rdata <= w_in_range ? mem_rdata : '0;
                r_c_err   <= ~w_in_range;
            end
        end
    end

    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;
    assign c_err     = r_c_err;
    assign d_err     = r_d_err;
    assign stall_cpu = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word RAM (ram[i] = i after init).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        c_ack, c_err, d_ack, d_err, stall_cpu, mem_we;
    logic        ram_init;
    logic [31:0] ram [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_BITS(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack), .c_err(c_err), .stall_cpu(stall_cpu),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[4:0]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= i;
        end else if (mem_we) begin
            ram[mem_addr[4:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        tick(); tick();
        rst = 1'b0; ram_init = 1'b0;
        #1;
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_acks", {c_ack, d_ack, c_err, d_err}, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);

        // CPU read of addr 5
        tick();
        c_req = 1; c_we = 0; c_addr = 5; #1;
        chk("rd5_c0_stall", stall_cpu, 1);
        chk("rd5_c0_addr", mem_addr, 0);
        tick();
        chk("rd5_c1_addr", mem_addr, 5);
        chk("rd5_c1_we", mem_we, 0);
        chk("rd5_c1_stall", stall_cpu, 1);
        chk("rd5_c1_ack", c_ack, 0);
        tick();
        chk("rd5_c2_ack", {c_ack, d_ack}, 2'b10);
        chk("rd5_c2_rdata", c_rdata, 32'h5);
        chk("rd5_c2_err", c_err, 0);
        chk("rd5_c2_stall", stall_cpu, 0);
        tick();
        c_req = 0; #1;
        chk("rd5_hold_rdata", c_rdata, 32'h5);
        chk("rd5_ack_pulse", c_ack, 0);

        // Debug write 0xDEADBEEF to addr 3, then CPU read-back
        d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'hDEADBEEF;
        tick();
        chk("dw3_acc_we", mem_we, 1);
        chk("dw3_acc_addr", mem_addr, 3);
        chk("dw3_acc_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        chk("dw3_ack_we", mem_we, 0);
        chk("dw3_ack", {c_ack, d_ack, d_err}, 3'b010);
        chk("dw3_ram", ram[3], 32'hDEADBEEF);
        tick();
        d_req = 0; d_we = 0;
        c_req = 1; c_we = 0; c_addr = 3; #1;
        tick(); tick();
        chk("rb3_ack", c_ack, 1);
        chk("rb3_rdata", c_rdata, 32'hDEADBEEF);
        tick();
        c_req = 0;

        // Out-of-range CPU write to 0x20
        c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'h1234_5678;
        tick();
        chk("oor_we", mem_we, 0);
        chk("oor_addr", mem_addr, 0);
        tick();
        chk("oor_ack", c_ack, 1);
        chk("oor_err", c_err, 1);
        chk("oor_rdata", c_rdata, 0);
        chk("oor_ram0", ram[0], 0);
        tick();
        c_req = 0; c_we = 0;

        // Simultaneous requests right after reset: C wins, then D, then C again
        rst = 1; tick(); rst = 0;
        c_req = 1; c_addr = 1; d_req = 1; d_we = 0; d_addr = 2; #1;
        chk("tie_c0_stall", stall_cpu, 1);
        tick(); tick();
        chk("tie_c2_acks", {c_ack, d_ack}, 2'b10);
        chk("tie_c2_rdata", c_rdata, 1);
        tick();
        c_req = 0; #1;
        tick(); tick();
        chk("tie_c5_acks", {c_ack, d_ack}, 2'b01);
        chk("tie_c5_rdata", d_rdata, 2);
        tick();
        c_req = 1; c_addr = 4; d_addr = 6; #1;
        tick(); tick();
        chk("tie2_acks", {c_ack, d_ack}, 2'b10);
        chk("tie2_rdata", c_rdata, 4);
        tick();
        c_req = 0; #1;
        tick(); tick();
        chk("tie2_d_acks", {c_ack, d_ack}, 2'b01);
        chk("tie2_d_rdata", d_rdata, 6);
        tick();
        d_req = 0;

        // Reset during ACC of a debug write of 0x7 to addr 8
        d_req = 1; d_we = 1; d_addr = 8; d_wdata = 32'h7;
        tick();
        rst = 1; #1;
        chk("racc_we", mem_we, 1);
        tick();
        rst = 0; d_req = 0; d_we = 0; #1;
        chk("racc_ram8", ram[8], 32'h7);
        chk("racc_acks", {c_ack, d_ack, c_err, d_err}, 0);
        chk("racc_rdata", d_rdata, 0);
        chk("racc_mem", {mem_we, mem_addr, mem_wdata}, 0);
        tick();
        chk("racc_idle_ack", d_ack, 0);

        // Reset during ACK: ack drops at the reset edge
        c_req = 1; c_addr = 5;
        tick(); tick();
        chk("rack_ack_before", c_ack, 1);
        rst = 1;
        tick();
        rst = 0; c_req = 0; #1;
        chk("rack_ack_after", c_ack, 0);
        chk("rack_rdata", c_rdata, 0);

        // Continuous CPU reads with a waiting debug port interleave C, D, C, D
        tick();
        c_req = 1; c_we = 0; c_addr = 9; d_req = 1; d_we = 0; d_addr = 10; #1;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("rr_cyc%0d_acks", k), {c_ack, d_ack},
                {1'(k % 6 == 2), 1'(k % 6 == 5)});
            tick();
        end
        c_req = 0; d_req = 0;
        chk("rr_c_rdata", c_rdata, 9);
        chk("rr_d_rdata", d_rdata, 10);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the 32-word data RAM in the MEM stage of the pipelined CPU.
- Shares the single RAM port between two requesters: the CPU MEM stage (port C) and the debug/loader port (port D).
- Tie-breaking is round-robin. Each access is a fixed 3-state req/ack transaction.
- Drives the RAM's we/addr/datain and captures its combinational dataout into a per-port registered read-data output.

Parameters:
- ADDR_BITS, 5, word-address bits actually decoded by the RAM (depth 2^ADDR_BITS = 32).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  CPU request; held high until c_ack.
- c_we  in  1  CPU write enable (1 = write, 0 = read).
- c_addr  in  32  CPU word address.
- c_wdata  in  DATA_W  CPU write data.
- c_rdata  out  DATA_W  CPU read data, valid while c_ack = 1.
- c_ack  out  1  CPU transaction-complete pulse.
- c_err  out  1  CPU address-out-of-range flag, valid with c_ack.
- stall_cpu  out  1  combinational, equals c_req & ~c_ack; drives the pipeline stall.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack, d_err: same as the c_* ports, for the debug/loader port.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM address; upper bits forced to 0.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- States:
  - IDLE: arbitrate among sampled requests.
  - ACC: RAM driven for exactly one cycle.
  - ACK: acknowledge the granted port.
- Transitions:
  - IDLE -> ACC when c_req | d_req.
  - ACC -> ACK always.
  - ACK -> IDLE always.
- Latency: a request seen in IDLE on cycle N gives ACC on N+1 and ack on N+2. Back-to-back accesses to the same port therefore take 3 cycles each.
- Grant register g (0 = C, 1 = D) is loaded in IDLE:
  - only one port requesting: grant that port.
  - both requesting: grant !last_grant.
  - last_grant is updated on entry to ACC.
- Reset: state = IDLE, last_grant = 1, so the CPU wins the first tie.
- In ACC:
  - mem_addr = {0, granted addr[ADDR_BITS-1:0]}.
  - mem_wdata = granted wdata.
  - mem_we = granted we & in_range, where in_range = (addr[31:ADDR_BITS] == 0).
  - At the closing edge, mem_rdata is captured into the granted port's rdata register, or 0 if out of range. The err register is set to !in_range.
- Outside ACC: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- In ACK: the granted port's ack = 1 for exactly one cycle, and err is valid alongside it. The other port's ack stays 0.
- Out-of-range access: no write is performed, rdata = 0, err = 1, and ack is still issued.
- Requester contract:
  - req, we, addr and wdata are held stable from req rise until the ack cycle.
  - req is dropped at the edge ending the ack cycle.
  - A req still high in IDLE after ACK starts a new transaction.
- The non-granted port keeps waiting; its req stays high and it wins the next arbitration.
- rdata registers hold their value until the next access to the same port.
- Reset values:
  - c_rdata = 0, d_rdata = 0.
  - c_ack = 0, d_ack = 0.
  - c_err = 0, d_err = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Reset during ACC: that cycle's RAM write still commits at the edge (the RAM has no reset). State goes to IDLE, no ack is issued, and rdata/err are cleared.
- Reset during ACK: the ack drops immediately at the reset edge.

Test Plan:
- CPU read of addr 5 (RAM holds 0x5): c_req at cycle 0 -> mem_addr = 5 at cycle 1; c_ack = 1 with c_rdata = 0x00000005, c_err = 0 at cycle 2; stall_cpu = 1 on cycles 0-1 and 0 on cycle 2.
- Debug write 0xDEADBEEF to addr 3, then CPU read of addr 3 -> mem_we = 1 for exactly one cycle; CPU then gets c_rdata = 0xDEADBEEF.
- c_req and d_req rise together after reset, both held -> C granted first (acks at cycle 2), then D (acks at cycle 5); next simultaneous pair -> C then D again, alternating.
- CPU write to addr 0x20 -> mem_we stays 0; c_ack = 1 with c_err = 1 and c_rdata = 0; RAM contents unchanged.
- rst asserted during ACC of a debug write of 0x7 to addr 8 -> ram[8] = 0x7, no d_ack, state IDLE, all outputs 0 next cycle.
- CPU continuous reads (req reasserted immediately after each ack) while debug requests -> accesses interleave C, D, C, D; neither port waits more than 6 cycles.
